audio_out_scheduler: RTL and testbench

//  Sequences the I2S master: picks one stereo frame per I2S frame from two sample requesters and launches it.
//  - src0: music player. src1: system sounds/beeps.
//  - Arbitration is either priority or saturating mix.
//  - Pulses i2s_send for one frame at a time, so the master returns to idle between frames.
//  - On underrun, optionally sends zero frames so BCLK/LRCK keep running; counts underruns; watchdogs a hung master.

---
 rtl/audio_out_scheduler.sv | 157 +++++++++++++++
 tb/tb_audio_out_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_out_scheduler.sv
// Frame scheduler in front of the I2S master: picks or mixes one stereo frame from two
// sample sources, launches it, and waits for the master to go busy and return to idle.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  IDLE      | waiting for enable, master idle and a selectable frame
//  LAUNCH    | send and ready pulses high for this single cycle
//  WAIT_BUSY | waiting for the master to drop done (watchdog running)
//  WAIT_DONE | waiting for the master to raise done (watchdog running)
module audio_out_scheduler #(
   parameter int DATA_BITS      = 16,
   parameter int KEEPALIVE      = 1,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_BITS       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable_i,
   input  logic                 mix_mode_i,
   input  logic                 src0_valid_i,
   input  logic [DATA_BITS-1:0] src0_data_L_i,
   input  logic [DATA_BITS-1:0] src0_data_R_i,
   output logic                 src0_ready_o,
   input  logic                 src1_valid_i,
   input  logic [DATA_BITS-1:0] src1_data_L_i,
   input  logic [DATA_BITS-1:0] src1_data_R_i,
   output logic                 src1_ready_o,
   output logic [DATA_BITS-1:0] i2s_sample_data_L_o,
   output logic [DATA_BITS-1:0] i2s_sample_data_R_o,
   output logic                 i2s_send_o,
   input  logic                 i2s_done_i,
   output logic [1:0]           active_src_o,
   output logic [CNT_BITS-1:0]  underrun_cnt_o,
   output logic                 timeout_err_o
);

   localparam int WD_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   state_t               state;
   logic [WD_BITS-1:0]   wd_cnt;

   logic                 sel_valid;
   logic                 sel_keepalive;
   logic                 sel_rdy0;
   logic                 sel_rdy1;
   logic [1:0]           sel_active;
   logic [DATA_BITS-1:0] sel_l;
   logic [DATA_BITS-1:0] sel_r;

   // Sign-extend by one bit; overflow shows up as the two top bits disagreeing.
   function automatic logic [DATA_BITS-1:0] sat_add(input logic [DATA_BITS-1:0] a,
                                                    input logic [DATA_BITS-1:0] b);
      logic [DATA_BITS:0] s;
      s = {a[DATA_BITS-1], a} + {b[DATA_BITS-1], b};
      if (s[DATA_BITS] != s[DATA_BITS-1])
         sat_add = {s[DATA_BITS], {(DATA_BITS-1){~s[DATA_BITS]}}};
      else
         sat_add = s[DATA_BITS-1:0];
   endfunction

   always_comb begin
      sel_valid     = 1'b0;
      sel_keepalive = 1'b0;
      sel_rdy0      = 1'b0;
      sel_rdy1      = 1'b0;
      sel_active    = 2'b00;
      sel_l         = '0;
      sel_r         = '0;
      if (mix_mode_i && src0_valid_i && src1_valid_i) begin
         sel_valid  = 1'b1;
         sel_rdy0   = 1'b1;
         sel_rdy1   = 1'b1;
         sel_active = 2'b11;
         sel_l      = sat_add(src0_data_L_i, src1_data_L_i);
         sel_r      = sat_add(src0_data_R_i, src1_data_R_i);
      end else if (src1_valid_i) begin
         sel_valid  = 1'b1;
         sel_rdy1   = 1'b1;
         sel_active = 2'b10;
         sel_l      = src1_data_L_i;
         sel_r      = src1_data_R_i;
      end else if (src0_valid_i) begin
         sel_valid  = 1'b1;
         sel_rdy0   = 1'b1;
         sel_active = 2'b01;
         sel_l      = src0_data_L_i;
         sel_r      = src0_data_R_i;
      end else if (KEEPALIVE != 0) begin
         sel_valid     = 1'b1;
         sel_keepalive = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         wd_cnt              <= '0;
         i2s_send_o          <= 1'b0;
         src0_ready_o        <= 1'b0;
         src1_ready_o        <= 1'b0;
         i2s_sample_data_L_o <= '0;
         i2s_sample_data_R_o <= '0;
         active_src_o        <= 2'b00;
         underrun_cnt_o      <= '0;
         timeout_err_o       <= 1'b0;
      end else begin
         i2s_send_o   <= 1'b0;
         src0_ready_o <= 1'b0;
         src1_ready_o <= 1'b0;
         case (state)
            IDLE: begin
               if (enable_i && i2s_done_i && sel_valid) begin
                  i2s_sample_data_L_o <= sel_l;
                  i2s_sample_data_R_o <= sel_r;
                  active_src_o        <= sel_active;
                  src0_ready_o        <= sel_rdy0;
                  src1_ready_o        <= sel_rdy1;
                  i2s_send_o          <= 1'b1;
                  if (sel_keepalive && (underrun_cnt_o != {CNT_BITS{1'b1}}))
                     underrun_cnt_o <= underrun_cnt_o + 1'b1;
                  state <= LAUNCH;
               end
            end
            LAUNCH: begin
               wd_cnt <= '0;
               state  <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (wd_cnt == WD_LAST) begin
                  timeout_err_o <= 1'b1;
                  state         <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
                  if (!i2s_done_i)
                     state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               // A frame that completes on the last watchdog cycle is not an error.
               if (i2s_done_i) begin
                  state <= IDLE;
               end else if (wd_cnt == WD_LAST) begin
                  timeout_err_o <= 1'b1;
                  state         <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_out_scheduler.sv
// Directed bench for audio_out_scheduler with a simple I2S master model; a second
// instance built without keepalive shares the inputs.
module tb_audio_out_scheduler;

   localparam int DB        = 16;
   localparam int TO        = 16;
   localparam int CB        = 16;
   localparam int FRAME_LEN = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          mix_mode;
   logic          src0_valid;
   logic [DB-1:0] src0_l;
   logic [DB-1:0] src0_r;
   logic          src1_valid;
   logic [DB-1:0] src1_l;
   logic [DB-1:0] src1_r;
   logic          i2s_done;
   logic          hang;

   logic          rdy0, rdy1, send0;
   logic [DB-1:0] data_l, data_r;
   logic [1:0]    active;
   logic [CB-1:0] underrun;
   logic          tmo_err;

   logic          rdy0_k, rdy1_k, send_k;
   logic [DB-1:0] data_l_k, data_r_k;
   logic [1:0]    active_k;
   logic [CB-1:0] underrun_k;
   logic          tmo_err_k;

   int n_checks = 0;
   int n_errors = 0;
   int n_send   = 0;
   int n_send_k = 0;
   int n_r0     = 0;
   int n_r1     = 0;
   int busy_cnt = 0;

   always #5 clk = ~clk;

   audio_out_scheduler #(.DATA_BITS(DB), .KEEPALIVE(1), .TIMEOUT_CYCLES(TO), .CNT_BITS(CB)) dut (
      .clk(clk), .rst(rst), .enable_i(enable), .mix_mode_i(mix_mode),
      .src0_valid_i(src0_valid), .src0_data_L_i(src0_l), .src0_data_R_i(src0_r), .src0_ready_o(rdy0),
      .src1_valid_i(src1_valid), .src1_data_L_i(src1_l), .src1_data_R_i(src1_r), .src1_ready_o(rdy1),
      .i2s_sample_data_L_o(data_l), .i2s_sample_data_R_o(data_r), .i2s_send_o(send0),
      .i2s_done_i(i2s_done), .active_src_o(active), .underrun_cnt_o(underrun), .timeout_err_o(tmo_err)
   );

   audio_out_scheduler #(.DATA_BITS(DB), .KEEPALIVE(0), .TIMEOUT_CYCLES(TO), .CNT_BITS(CB)) dut_nokeep (
      .clk(clk), .rst(rst), .enable_i(enable), .mix_mode_i(mix_mode),
      .src0_valid_i(src0_valid), .src0_data_L_i(src0_l), .src0_data_R_i(src0_r), .src0_ready_o(rdy0_k),
      .src1_valid_i(src1_valid), .src1_data_L_i(src1_l), .src1_data_R_i(src1_r), .src1_ready_o(rdy1_k),
      .i2s_sample_data_L_o(data_l_k), .i2s_sample_data_R_o(data_r_k), .i2s_send_o(send_k),
      .i2s_done_i(i2s_done), .active_src_o(active_k), .underrun_cnt_o(underrun_k), .timeout_err_o(tmo_err_k)
   );

   // I2S master: drops done the cycle after a send, raises it FRAME_LEN cycles later unless hung.
   always @(posedge clk) begin
      if (rst) begin
         i2s_done <= 1'b1;
         busy_cnt <= 0;
      end else if (send0) begin
         i2s_done <= 1'b0;
         busy_cnt <= FRAME_LEN;
      end else if (busy_cnt != 0 && !hang) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) i2s_done <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (send0)  n_send++;
      if (send_k) n_send_k++;
      if (rdy0)   n_r0++;
      if (rdy1)   n_r1++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_send(input int max_cycles, input string tag);
      int i;
      i = 0;
      do begin
         tick();
         i++;
      end while (!send0 && i < max_cycles);
      check(tag, 32'(send0), 32'd1);
   endtask

   task automatic clear_counts();
      n_send = 0; n_send_k = 0; n_r0 = 0; n_r1 = 0;
   endtask

   initial begin
      int gap;
      rst = 1'b1; enable = 1'b1; mix_mode = 1'b0; hang = 1'b0;
      src0_valid = 1'b1; src0_l = 16'h1357; src0_r = 16'h2468;
      src1_valid = 1'b0; src1_l = '0; src1_r = '0;

      // Reset held three cycles with a valid source present
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_send", 32'(send0), 32'd0);
      end
      check("rst_data_l", 32'(data_l), 32'd0);
      check("rst_data_r", 32'(data_r), 32'd0);
      check("rst_ready", 32'({rdy1, rdy0}), 32'd0);
      check("rst_active", 32'(active), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_tmo", 32'(tmo_err), 32'd0);
      rst = 1'b0;
      clear_counts();
      wait_send(2, "post_rst_send");
      check("post_rst_data_l", 32'(data_l), 32'h1357);
      check("post_rst_data_r", 32'(data_r), 32'h2468);
      check("post_rst_active", 32'(active), 32'b01);
      check("post_rst_rdy0", 32'(rdy0), 32'd1);
      src0_valid = 1'b0; enable = 1'b0;
      ticks(10);

      // Priority: src1 wins, src0 must keep waiting
      clear_counts();
      mix_mode = 1'b0;
      src0_valid = 1'b1; src0_l = 16'h1111; src0_r = 16'h2222;
      src1_valid = 1'b1; src1_l = 16'h0AAA; src1_r = 16'h0BBB;
      enable = 1'b1;
      wait_send(12, "prio_send");
      check("prio_data_l", 32'(data_l), 32'h0AAA);
      check("prio_data_r", 32'(data_r), 32'h0BBB);
      check("prio_active", 32'(active), 32'b10);
      src1_valid = 1'b0; enable = 1'b0;
      ticks(10);
      check("prio_n_r1", 32'(n_r1), 32'd1);
      check("prio_n_r0", 32'(n_r0), 32'd0);
      check("prio_n_send", 32'(n_send), 32'd1);
      check("prio_hold_l", 32'(data_l), 32'h0AAA);

      // Priority with only src0
      clear_counts();
      enable = 1'b1;
      wait_send(12, "p0_send");
      check("p0_data_l", 32'(data_l), 32'h1111);
      check("p0_active", 32'(active), 32'b01);
      src0_valid = 1'b0; enable = 1'b0;
      ticks(10);
      check("p0_n_r0", 32'(n_r0), 32'd1);

      // Saturating mix, both directions
      clear_counts();
      mix_mode = 1'b1;
      src0_valid = 1'b1; src0_l = 16'h7000; src0_r = 16'h9000;
      src1_valid = 1'b1; src1_l = 16'h2000; src1_r = 16'hA000;
      enable = 1'b1;
      wait_send(12, "mixsat_send");
      check("mixsat_data_l", 32'(data_l), 32'h7FFF);
      check("mixsat_data_r", 32'(data_r), 32'h8000);
      check("mixsat_active", 32'(active), 32'b11);
      src0_valid = 1'b0; src1_valid = 1'b0; enable = 1'b0;
      ticks(10);
      check("mixsat_readys", 32'({n_r1[3:0], n_r0[3:0]}), 32'h11);

      // Mix without saturation, signed
      clear_counts();
      src0_valid = 1'b1; src0_l = 16'h0100; src0_r = 16'hFF00;
      src1_valid = 1'b1; src1_l = 16'h0023; src1_r = 16'h0010;
      enable = 1'b1;
      wait_send(12, "mix_send");
      check("mix_data_l", 32'(data_l), 32'h0123);
      check("mix_data_r", 32'(data_r), 32'hFF10);
      src0_valid = 1'b0; enable = 1'b0;
      ticks(10);

      // Mix mode with a single valid source passes it through
      clear_counts();
      src1_l = 16'h4321; src1_r = 16'h8765;
      enable = 1'b1;
      wait_send(12, "mix1_send");
      check("mix1_data_l", 32'(data_l), 32'h4321);
      check("mix1_data_r", 32'(data_r), 32'h8765);
      check("mix1_active", 32'(active), 32'b10);
      src1_valid = 1'b0; enable = 1'b0;
      ticks(10);
      check("mix1_n_r0", 32'(n_r0), 32'd0);

      // Underrun: five keepalive frames; the no-keepalive instance stays idle
      clear_counts();
      mix_mode = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 60 && n_send < 5; i++) begin
         tick();
         if (send0) begin
            check("ka_data", 32'({data_l, data_r}), 32'd0);
            if (n_send == 5) enable = 1'b0;
         end
      end
      enable = 1'b0;
      ticks(10);
      check("ka_n_send", 32'(n_send), 32'd5);
      check("ka_underrun", 32'(underrun), 32'd5);
      check("ka_active", 32'(active), 32'b00);
      check("nokeep_send", 32'(n_send_k), 32'd0);
      check("nokeep_underrun", 32'(underrun_k), 32'd0);

      // Watchdog: master never returns done
      clear_counts();
      hang = 1'b1;
      src0_valid = 1'b1; src0_l = 16'h00AA; src0_r = 16'h00BB;
      enable = 1'b1;
      wait_send(12, "tmo_send");
      src0_valid = 1'b0; enable = 1'b0;
      ticks(TO);
      check("tmo_not_early", 32'(tmo_err), 32'd0);
      tick();
      check("tmo_set", 32'(tmo_err), 32'd1);
      hang = 1'b0;
      ticks(10);
      check("tmo_sticky", 32'(tmo_err), 32'd1);

      // Back-to-back frames from an always-valid src0
      clear_counts();
      src0_valid = 1'b1; src0_l = 16'h0100; src0_r = 16'h0200;
      enable = 1'b1;
      for (int k = 0; k < 6; k++) begin
         gap = 0;
         do begin
            tick();
            gap++;
         end while (!send0 && gap < 14);
         check("b2b_send", 32'(send0), 32'd1);
         if (k > 0) check("b2b_gap", 32'(gap), 32'd7);
         check("b2b_data_l", 32'(data_l), 32'h0100 + 32'(k));
         check("b2b_data_r", 32'(data_r), 32'h0200 + 32'(k));
         check("b2b_rdy0", 32'(rdy0), 32'd1);
         src0_l = 16'h0100 + 16'(k + 1);
         src0_r = 16'h0200 + 16'(k + 1);
         if (k == 5) enable = 1'b0;
      end
      ticks(10);
      check("b2b_n_send", 32'(n_send), 32'd6);
      check("b2b_n_r0", 32'(n_r0), 32'd6);
      check("b2b_tmo_sticky", 32'(tmo_err), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
